// File: rtl/mdr_mem_if.sv
// Memory data register with a handshaked memory read/write port and an optional timeout.
// Optional feature: define MDR_SIGN_EXT_EN to sign-extend byte/halfword read data according to size.
module mdr_mem_if #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             MDRin,
  input  logic             read,
  input  logic             write,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] BusMuxIn,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic             expire;
  logic [WIDTH-1:0] rd_value;

`ifdef MDR_SIGN_EXT_EN
  logic [1:0] size_q, size_d;

  function automatic logic [WIDTH-1:0] ext_rdata(input logic [WIDTH-1:0] d, input logic [1:0] sz);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (sz)
      2'b00:   return WIDTH'(b);
      2'b01:   return WIDTH'(h);
      default: return d;
    endcase
  endfunction

  assign rd_value = ext_rdata(mem_rdata, size_q);
`else
  logic unused_size;
  assign unused_size = ^size;
  assign rd_value    = mem_rdata;
`endif

  // The final permitted wait cycle: completing here still wins over the timeout.
  assign expire = (TIMEOUT > 0) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
`ifdef MDR_SIGN_EXT_EN
    size_d  = size_q;
`endif
    case (state_q)
      IDLE: begin
        if (read) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
          terr_d  = 1'b0;
`ifdef MDR_SIGN_EXT_EN
          size_d  = size;
`endif
        end else if (write) begin
          state_d = WR_WAIT;
          cnt_d   = '0;
          terr_d  = 1'b0;
        end else if (MDRin) begin
          q_d = BusMuxOut;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ready) begin
          if (state_q == RD_WAIT) q_d = rd_value;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (expire) begin
            state_d = IDLE;
            terr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
`ifdef MDR_SIGN_EXT_EN
      size_q  <= 2'b10;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
`ifdef MDR_SIGN_EXT_EN
      size_q  <= size_d;
`endif
    end
  end

  assign mem_rd_req  = (state_q == RD_WAIT);
  assign mem_wr_req  = (state_q == WR_WAIT);
  assign busy        = (state_q != IDLE);
  assign mem_wdata   = q_q;
  assign BusMuxIn    = q_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Bench for mdr_mem_if: directed scenarios followed by random traffic against a transaction-level model.
module tb_mdr_mem_if;
  localparam int W  = 32;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear, MDRin, read, write, mem_ready;
  logic [1:0]    size;
  logic [W-1:0]  BusMuxOut, mem_rdata;
  logic          mem_rd_req, mem_wr_req, busy, done, timeout_err;
  logic [W-1:0]  mem_wdata, BusMuxIn;

  int total = 0;
  int bad   = 0;

  // Reference model: pending transfer kind (0 none, 1 read, 2 write) and cycles waited so far.
  logic [W-1:0]  m_q;
  int            m_mode, m_waited;
  logic          m_done, m_terr;
  logic [1:0]    m_size;

  mdr_mem_if #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .clear(clear), .MDRin(MDRin), .read(read), .write(write),
    .size(size), .BusMuxOut(BusMuxOut), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata),
    .BusMuxIn(BusMuxIn), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] model_ext(input logic [W-1:0] d, input logic [1:0] sz);
`ifdef MDR_SIGN_EXT_EN
    if (sz == 2'b00) return W'(int'(byte'(d[7:0])));
    if (sz == 2'b01) return W'(int'(shortint'(d[15:0])));
`endif
    return d;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},     BusMuxIn,    m_q);
    check({tag, ".wdata"}, mem_wdata,   m_q);
    check({tag, ".rdreq"}, W'(mem_rd_req), W'(m_mode == 1));
    check({tag, ".wrreq"}, W'(mem_wr_req), W'(m_mode == 2));
    check({tag, ".busy"},  W'(busy),    W'(m_mode != 0));
    check({tag, ".done"},  W'(done),    W'(m_done));
    check({tag, ".terr"},  W'(timeout_err), W'(m_terr));
  endtask

  task automatic model_reset();
    m_q = '0; m_mode = 0; m_waited = 0; m_done = 1'b0; m_terr = 1'b0; m_size = 2'b10;
  endtask

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (m_mode == 0) begin
      if (read) begin
        m_mode = 1; m_waited = 0; m_terr = 1'b0; m_size = size;
      end else if (write) begin
        m_mode = 2; m_waited = 0; m_terr = 1'b0;
      end else if (MDRin) begin
        m_q = BusMuxOut;
      end
    end else if (mem_ready) begin
      if (m_mode == 1) m_q = model_ext(mem_rdata, m_size);
      m_mode = 0;
      nd = 1'b1;
    end else begin
      m_waited++;
      if (TO > 0 && m_waited >= TO) begin
        m_mode = 0;
        m_terr = 1'b1;
      end
    end
    m_done = nd;
  endtask

  // Inputs are changed 1ns after an edge; the model follows the edge and outputs are checked 1ns later.
  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    MDRin = 0; read = 0; write = 0; mem_ready = 0;
  endtask

  task automatic pulse_clear(input string tag);
    clear = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    clear = 1'b0;
    #1;
  endtask

  initial begin
    int busy_cycles, done_count, wr_cycles;
    int ready_pct;
    clear = 1'b1; size = 2'b10; BusMuxOut = '0; mem_rdata = '0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    clear = 1'b0;

    // MDRin load from the bus
    MDRin = 1; BusMuxOut = 32'hDEADBEEF;
    tick("load");
    check("load.value", BusMuxIn, 32'hDEADBEEF);
    idle_inputs();

    // Read with three stall cycles
    read = 1; mem_rdata = 32'h12345678;
    tick("rd.cmd");
    read = 0;
    busy_cycles = 0; done_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cycles++;
      mem_ready = (i == 2);
      tick("rd.wait");
      mem_ready = 0;
      if (done) done_count++;
    end
    check("rd.busy_cycles", W'(busy_cycles), 32'd3);
    check("rd.done_count",  W'(done_count),  32'd1);
    check("rd.value",       BusMuxIn,        32'h12345678);

    // Byte read, sign-extended only when the feature is built in
    read = 1; size = 2'b00; mem_rdata = 32'h000000F0;
    tick("rdb.cmd");
    read = 0; size = 2'b10; mem_ready = 1;
    tick("rdb.ready");
    mem_ready = 0;
`ifdef MDR_SIGN_EXT_EN
    check("rdb.value", BusMuxIn, 32'hFFFFFFF0);
`else
    check("rdb.value", BusMuxIn, 32'h000000F0);
`endif

    // Write that never completes
    MDRin = 1; BusMuxOut = 32'hA5A5A5A5;
    tick("wr.load");
    MDRin = 0; write = 1;
    tick("wr.cmd");
    write = 0;
    wr_cycles = 0; done_count = 0;
    if (mem_wr_req) wr_cycles++;
    for (int i = 0; i < 20; i++) begin
      tick("wr.wait");
      if (mem_wr_req) wr_cycles++;
      if (done) done_count++;
    end
    check("wr.req_cycles", W'(wr_cycles),   32'd15);
    check("wr.done_count", W'(done_count),  32'd0);
    check("wr.terr",       W'(timeout_err), 32'd1);
    check("wr.q",          BusMuxIn,        32'hA5A5A5A5);

    // Clear in the middle of a read
    read = 1; mem_rdata = 32'h0BADF00D;
    tick("clr.cmd");
    read = 0;
    tick("clr.wait");
    pulse_clear("clr.async");
    mem_ready = 1;
    tick("clr.ready");
    mem_ready = 0;
    tick("clr.after");
    check("clr.q", BusMuxIn, 32'h0);

    // All three commands at once: read wins
    MDRin = 1; write = 1; read = 1; BusMuxOut = 32'h13579BDF;
    tick("prio");
    check("prio.rdreq", W'(mem_rd_req), 32'd1);
    check("prio.wrreq", W'(mem_wr_req), 32'd0);
    check("prio.q",     BusMuxIn,       32'h0);
    idle_inputs();
    mem_ready = 1; mem_rdata = 32'h00008001; size = 2'b01;
    tick("prio.done");
    mem_ready = 0;

    // Random traffic; the ready rate changes by segment so timeouts also occur
    for (int seg = 0; seg < 8; seg++) begin
      ready_pct = (seg % 4 == 3) ? 0 : 10 + 25 * (seg % 4);
      for (int i = 0; i < 200; i++) begin
        read      = ($urandom_range(0, 7) == 0);
        write     = ($urandom_range(0, 7) == 0);
        MDRin     = ($urandom_range(0, 3) == 0);
        mem_ready = ($urandom_range(0, 99) < ready_pct);
        size      = 2'($urandom_range(0, 3));
        BusMuxOut = $urandom;
        mem_rdata = $urandom;
        tick("rand");
        if ($urandom_range(0, 199) == 0) pulse_clear("rand.clear");
      end
    end
    idle_inputs();
    tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
